// File: rtl/req_ack_latency_monitor.sv
// rtl/req_ack_latency_monitor.sv - multi-channel req/ack protocol and latency checker
module req_ack_latency_monitor #(
  parameter int N_CH    = 4,
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 8,
  parameter int CNT_W   = 16,
  localparam int LAT_W  = $clog2(MAX_LAT + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH-1:0]         ack,
  input  logic                    clear,
  output logic [N_CH-1:0]         err_pulse,
  output logic [3*N_CH-1:0]       err_code,
  output logic [N_CH-1:0]         err_flag,
  output logic [N_CH-1:0]         busy,
  output logic [LAT_W*N_CH-1:0]   last_lat,
  output logic [CNT_W-1:0]        err_count,
  output logic [CNT_W-1:0]        xfer_count
);

  // Popcount of N_CH event bits, and the widened sum used for saturation
  localparam int PC_W  = $clog2(N_CH + 1);
  localparam int SUM_W = CNT_W + PC_W;

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_SPURIOUS = 3'd1;
  localparam logic [2:0] E_DROP     = 3'd2;
  localparam logic [2:0] E_EARLY    = 3'd3;
  localparam logic [2:0] E_TIMEOUT  = 3'd4;
  localparam logic [2:0] E_ACK_LONG = 3'd5;
  localparam logic [2:0] E_REQ_HOLD = 3'd6;

  localparam logic [LAT_W-1:0] MIN_L = LAT_W'(MIN_LAT);
  localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_TOUT
  } state_t;

  // Per-channel events decoded from the current state and this cycle's req/ack
  logic [N_CH-1:0] viol;
  logic [N_CH-1:0] cmpl;

  function automatic logic [PC_W-1:0] popcount(input logic [N_CH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int j = 0; j < N_CH; j++) begin
      c = c + PC_W'(v[j]);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) begin
      return {CNT_W{1'b1}};
    end
    return s[CNT_W-1:0];
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state;
    state_t           nxt_state;
    logic [LAT_W-1:0] lat;
    logic [LAT_W-1:0] nxt_lat;
    logic [2:0]       code;
    logic             done_ev;
    logic             pulse_q;
    logic [2:0]       code_q;
    logic             busy_q;
    logic [LAT_W-1:0] last_q;

    // Classify this cycle's req/ack against the channel state and pick the next state
    always_comb begin
      code      = E_NONE;
      done_ev   = 1'b0;
      nxt_state = state;
      nxt_lat   = lat;
      case (state)
        S_IDLE: begin
          if (req[i] && ack[i]) begin
            if (MIN_LAT > 0) begin
              code = E_EARLY;
            end else begin
              done_ev = 1'b1;
            end
            nxt_state = S_DONE;
            nxt_lat   = '0;
          end else if (req[i]) begin
            nxt_state = S_WAIT;
            nxt_lat   = LAT_W'(1);
          end else if (ack[i]) begin
            code = E_SPURIOUS;
          end
        end
        S_WAIT: begin
          if (!req[i]) begin
            // A dropped request outranks an ack arriving in the same cycle
            code      = E_DROP;
            nxt_state = S_IDLE;
            nxt_lat   = '0;
          end else if (ack[i]) begin
            if (lat < MIN_L) begin
              code = E_EARLY;
            end else begin
              done_ev = 1'b1;
            end
            nxt_state = S_DONE;
          end else if (lat == MAX_L) begin
            code      = E_TIMEOUT;
            nxt_state = S_TOUT;
          end else begin
            nxt_lat = lat + LAT_W'(1);
          end
        end
        S_DONE: begin
          if (ack[i]) begin
            code = E_ACK_LONG;
          end else if (req[i]) begin
            code = E_REQ_HOLD;
          end
          nxt_state = S_IDLE;
          nxt_lat   = '0;
        end
        S_TOUT: begin
          // Late acks are swallowed; only the release of req ends the episode
          if (!req[i]) begin
            nxt_state = S_IDLE;
            nxt_lat   = '0;
          end
        end
        default: begin
          nxt_state = S_IDLE;
          nxt_lat   = '0;
        end
      endcase
    end

    assign viol[i] = (code != E_NONE);
    assign cmpl[i] = done_ev;

    // Channel FSM with registered pulse, code, busy and last latency
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state   <= S_IDLE;
        lat     <= '0;
        pulse_q <= 1'b0;
        code_q  <= E_NONE;
        busy_q  <= 1'b0;
        last_q  <= '0;
      end else begin
        state   <= nxt_state;
        lat     <= nxt_lat;
        pulse_q <= (code != E_NONE);
        code_q  <= code;
        busy_q  <= (nxt_state == S_WAIT) || (nxt_state == S_TOUT);
        if (done_ev) begin
          last_q <= (state == S_IDLE) ? '0 : lat;
        end
      end
    end

    assign err_pulse[i]                 = pulse_q;
    assign err_code[3*i +: 3]           = code_q;
    assign busy[i]                      = busy_q;
    assign last_lat[LAT_W*i +: LAT_W]   = last_q;
  end

  // Sticky flags and saturating totals; clear discards this cycle's events
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flag   <= '0;
      err_count  <= '0;
      xfer_count <= '0;
    end else if (clear) begin
      err_flag   <= '0;
      err_count  <= '0;
      xfer_count <= '0;
    end else begin
      err_flag   <= err_flag | viol;
      err_count  <= sat_add(err_count, popcount(viol));
      xfer_count <= sat_add(xfer_count, popcount(cmpl));
    end
  end

endmodule
